// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receive path.
// - FSM state encoding for the element/sequence tracker.
// - SOS reference pattern (newest element in bit 0, 1 = dash) and its length.
// - Default timing constants in clock cycles at 48 MHz. The dot/dash/gap values
//   are the same ones the upstream blinker uses to key its LED.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        EMIT  = 2'd3
    } state_t;

    localparam int          CNT_W       = 25;
    localparam logic [4:0]  SEQ_MAX     = 5'd16;
    localparam logic [4:0]  SOS_LEN     = 5'd9;
    localparam logic [8:0]  SOS_PATTERN = 9'b000_111_000;

    // Blinker keying constants.
    localparam logic [CNT_W-1:0] DOT_CYC   = 25'h493E00;
    localparam logic [CNT_W-1:0] DASH_CYC  = 25'hDBBA00;
    localparam logic [CNT_W-1:0] ELEM_GAP  = 25'h500000;
    localparam logic [CNT_W-1:0] REST_CYC  = 25'hFFFFFF;

    // Receiver thresholds derived from the keying constants.
    localparam logic [15:0]      DEB_CYC_DEF  = 16'd48000;
    localparam logic [CNT_W-1:0] MIN_MARK_DEF = 25'h0BB800;
    localparam logic [CNT_W-1:0] DASH_THR_DEF = 25'h927C00;
    localparam logic [CNT_W-1:0] WORD_GAP_DEF = 25'hC00000;

    // True when a finished sequence is exactly S-O-S.
    function automatic logic is_sos(input logic [4:0] len,
                                    input logic [15:0] bits,
                                    input logic ovf);
        return (len == SOS_LEN) && (bits[8:0] == SOS_PATTERN) && !ovf;
    endfunction

endpackage

// File: rtl/morse_debounce.sv
// Input conditioner for the keyed line.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset (filtered level returns to idle = 1)
//   key_n    raw asynchronous keyed input, active-low
//   key_filt synchronised, debounced level
// The raw line goes through a two-flop synchroniser; the filtered level only
// follows the synchronised value once it has differed for DEB_CYC consecutive
// cycles, so both edges are delayed equally and mark/space widths are kept.
module morse_debounce
    import morse_pkg::*;
#(
    parameter logic [15:0] DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_filt
);

    logic        sync1_reg;
    logic        sync2_reg;
    logic        filt_reg;
    logic [15:0] stab_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            filt_reg  <= 1'b1;
            stab_reg  <= 16'd0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            if (sync2_reg == filt_reg) begin
                // Any bounce back to the current level restarts the count.
                stab_reg <= 16'd0;
            end else if (stab_reg == DEB_CYC - 16'd1) begin
                filt_reg <= sync2_reg;
                stab_reg <= 16'd0;
            end else begin
                stab_reg <= stab_reg + 16'd1;
            end
        end
    end

    assign key_filt = filt_reg;

endmodule

// File: rtl/morse_detect.sv
// Morse receiver: times marks and spaces of the debounced key, classifies each
// accepted mark as dot or dash, gathers elements into a sequence that ends on a
// word-length space, and flags S-O-S.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   key_n      keyed input, active-low (0 = mark)
//   sym_valid  1-cycle pulse per accepted element, sym_dash = 1 for a dash
//   seq_valid  1-cycle pulse when a sequence ends
//   seq_len    element count of the last sequence (0..16), held
//   seq_bits   last sequence, bit 0 = newest element, 1 = dash, held
//   seq_ovf    last sequence had more than 16 elements, held
//   sos_det    1-cycle pulse with seq_valid when the sequence is SOS
//   led_g      active-low status LED, lit from an SOS until a non-SOS sequence
module morse_detect
    import morse_pkg::*;
#(
    parameter logic [15:0]      DEB_CYC  = DEB_CYC_DEF,
    parameter logic [CNT_W-1:0] MIN_MARK = MIN_MARK_DEF,
    parameter logic [CNT_W-1:0] DASH_THR = DASH_THR_DEF,
    parameter logic [CNT_W-1:0] WORD_GAP = WORD_GAP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_n,
    output logic        sym_valid,
    output logic        sym_dash,
    output logic        seq_valid,
    output logic [4:0]  seq_len,
    output logic [15:0] seq_bits,
    output logic        seq_ovf,
    output logic        sos_det,
    output logic        led_g
);

    logic key_filt;
    logic mark;

    morse_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .key_n    (key_n),
        .key_filt (key_filt)
    );

    assign mark = ~key_filt;

    state_t           state_reg,     state_next;
    logic [CNT_W-1:0] cnt_reg,       cnt_next;
    logic [4:0]       len_reg,       len_next;
    logic [15:0]      bits_reg,      bits_next;
    logic             ovf_reg,       ovf_next;
    logic             sym_valid_reg, sym_valid_next;
    logic             sym_dash_reg,  sym_dash_next;
    logic             seq_valid_reg, seq_valid_next;
    logic [4:0]       seq_len_reg,   seq_len_next;
    logic [15:0]      seq_bits_reg,  seq_bits_next;
    logic             seq_ovf_reg,   seq_ovf_next;
    logic             sos_reg,       sos_next;
    logic             led_reg,       led_next;

    logic [CNT_W-1:0] cnt_inc;
    logic             is_dash;

    // Saturating duration count: a mark held forever parks at all-ones.
    assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + 25'd1;
    assign is_dash = (cnt_reg >= DASH_THR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            len_reg       <= '0;
            bits_reg      <= '0;
            ovf_reg       <= 1'b0;
            sym_valid_reg <= 1'b0;
            sym_dash_reg  <= 1'b0;
            seq_valid_reg <= 1'b0;
            seq_len_reg   <= '0;
            seq_bits_reg  <= '0;
            seq_ovf_reg   <= 1'b0;
            sos_reg       <= 1'b0;
            led_reg       <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            len_reg       <= len_next;
            bits_reg      <= bits_next;
            ovf_reg       <= ovf_next;
            sym_valid_reg <= sym_valid_next;
            sym_dash_reg  <= sym_dash_next;
            seq_valid_reg <= seq_valid_next;
            seq_len_reg   <= seq_len_next;
            seq_bits_reg  <= seq_bits_next;
            seq_ovf_reg   <= seq_ovf_next;
            sos_reg       <= sos_next;
            led_reg       <= led_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        len_next       = len_reg;
        bits_next      = bits_reg;
        ovf_next       = ovf_reg;
        sym_valid_next = 1'b0;
        sym_dash_next  = 1'b0;
        seq_valid_next = 1'b0;
        seq_len_next   = seq_len_reg;
        seq_bits_next  = seq_bits_reg;
        seq_ovf_next   = seq_ovf_reg;
        sos_next       = 1'b0;
        led_next       = led_reg;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (mark) begin
                    state_next = MARK;
                    cnt_next   = 25'd1;
                end
            end

            MARK: begin
                if (mark) begin
                    cnt_next = cnt_inc;
                end else if (cnt_reg < MIN_MARK) begin
                    // Noise: drop it; an open sequence keeps waiting for
                    // its word gap, measured afresh from this fall.
                    if (len_reg != 5'd0) begin
                        state_next = SPACE;
                        cnt_next   = 25'd1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    sym_valid_next = 1'b1;
                    sym_dash_next  = is_dash;
                    bits_next      = {bits_reg[14:0], is_dash};
                    if (len_reg == SEQ_MAX) begin
                        ovf_next = 1'b1;
                    end else begin
                        len_next = len_reg + 5'd1;
                    end
                    state_next = SPACE;
                    cnt_next   = 25'd1;
                end
            end

            SPACE: begin
                // Word gap wins over a mark starting in the same cycle.
                if (cnt_reg == WORD_GAP) begin
                    state_next = EMIT;
                end else if (mark) begin
                    state_next = MARK;
                    cnt_next   = 25'd1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            EMIT: begin
                seq_valid_next = 1'b1;
                seq_len_next   = len_reg;
                seq_bits_next  = bits_reg;
                seq_ovf_next   = ovf_reg;
                sos_next       = is_sos(len_reg, bits_reg, ovf_reg);
                led_next       = ~is_sos(len_reg, bits_reg, ovf_reg);
                len_next       = '0;
                bits_next      = '0;
                ovf_next       = 1'b0;
                cnt_next       = '0;
                state_next     = IDLE;
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign sym_valid = sym_valid_reg;
    assign sym_dash  = sym_dash_reg;
    assign seq_valid = seq_valid_reg;
    assign seq_len   = seq_len_reg;
    assign seq_bits  = seq_bits_reg;
    assign seq_ovf   = seq_ovf_reg;
    assign sos_det   = sos_reg;
    assign led_g     = led_reg;

endmodule

// File: tb/tb_morse_detect.sv
// Self-checking bench for morse_detect with shortened timing constants.
// Key activity is described as filtered mark/space durations; a behavioural
// model turns those durations into the expected element and sequence reports.
module tb_morse_detect;

    localparam int DEB = 4;
    localparam int MINM = 10;
    localparam int DTHR = 100;
    localparam int WG = 400;
    localparam int FLUSH = 500;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_n = 1'b1;
    logic        sym_valid;
    logic        sym_dash;
    logic        seq_valid;
    logic [4:0]  seq_len;
    logic [15:0] seq_bits;
    logic        seq_ovf;
    logic        sos_det;
    logic        led_g;

    morse_detect #(
        .DEB_CYC  (16'd4),
        .MIN_MARK (25'd10),
        .DASH_THR (25'd100),
        .WORD_GAP (25'd400)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .sym_valid (sym_valid),
        .sym_dash  (sym_dash),
        .seq_valid (seq_valid),
        .seq_len   (seq_len),
        .seq_bits  (seq_bits),
        .seq_ovf   (seq_ovf),
        .sos_det   (sos_det),
        .led_g     (led_g)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int bits;
        bit ovf;
        bit sos;
        bit led;
    } seq_rec_t;

    int n_checks = 0;
    int n_fail = 0;

    bit       m_elems[$];
    bit       exp_sym[$];
    bit       obs_sym[$];
    seq_rec_t exp_seq[$];
    seq_rec_t obs_seq[$];
    seq_rec_t last_exp;
    bit       exp_led;
    int       last_space;
    bit       sos_ref [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Observe DUT pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (sym_valid) begin
                obs_sym.push_back(sym_dash);
                $display("sym   dash=%0d t=%0t", sym_dash, $time);
            end
            if (seq_valid) begin
                seq_rec_t r;
                r.len  = int'(seq_len);
                r.bits = int'(seq_bits);
                r.ovf  = seq_ovf;
                r.sos  = sos_det;
                r.led  = led_g;
                obs_seq.push_back(r);
                $display("seq   len=%0d bits=%04h ovf=%0d sos=%0d led_g=%0d t=%0t",
                         seq_len, seq_bits, seq_ovf, sos_det, led_g, $time);
            end
            if (sos_det && !seq_valid)
                check("sos_without_seq", 32'(sos_det), 32'd0);
        end
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_elems.delete();
        exp_sym.delete();
        exp_seq.delete();
        obs_sym.delete();
        obs_seq.delete();
        last_exp   = '{len: 0, bits: 0, ovf: 0, sos: 0, led: 1};
        exp_led    = 1'b1;
        last_space = 100000;
    endtask

    task automatic model_emit();
        seq_rec_t r;
        int b;
        bit match;
        b = 0;
        foreach (m_elems[i]) b = ((b << 1) | int'(m_elems[i])) & 16'hFFFF;
        match = (m_elems.size() == 9);
        if (match) foreach (sos_ref[i]) if (m_elems[i] != sos_ref[i]) match = 0;
        r.len  = (m_elems.size() > 16) ? 16 : m_elems.size();
        r.bits = b;
        r.ovf  = (m_elems.size() > 16);
        r.sos  = match;
        r.led  = !match;
        exp_seq.push_back(r);
        last_exp = r;
        exp_led  = r.led;
        m_elems.delete();
    endtask

    // A space closing an open sequence ends it once it reaches WG. When the
    // gap ends right at the threshold the following mark is picked up
    // one or two cycles late and so measures that much shorter.
    task automatic model_gap_end(input int s, output int shorten);
        shorten = 0;
        if (m_elems.size() > 0 && s >= WG) begin
            shorten = (s == WG) ? 2 : ((s == WG + 1) ? 1 : 0);
            model_emit();
        end
    endtask

    task automatic model_mark(input int n, input int shorten);
        int eff;
        eff = n - shorten;
        if (eff >= MINM) begin
            exp_sym.push_back(eff >= DTHR);
            m_elems.push_back(eff >= DTHR);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input logic lvl, input int n);
        key_n = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_mark(input int n);
        int sh;
        model_gap_end(last_space, sh);
        model_mark(n, sh);
        drive(1'b0, n);
    endtask

    task automatic send_space(input int s);
        last_space = s;
        drive(1'b1, s);
    endtask

    task automatic flush();
        int sh;
        send_space(FLUSH);
        model_gap_end(FLUSH, sh);
        drive(1'b1, 10);
    endtask

    task automatic compare_all(input string ph);
        #1;
        check({ph, "_sym_count"}, obs_sym.size(), exp_sym.size());
        for (int i = 0; i < exp_sym.size() && i < obs_sym.size(); i++)
            check({ph, "_sym_dash"}, 32'(obs_sym[i]), 32'(exp_sym[i]));
        check({ph, "_seq_count"}, obs_seq.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < obs_seq.size(); i++) begin
            check({ph, "_seq_len"},  obs_seq[i].len,       exp_seq[i].len);
            check({ph, "_seq_bits"}, obs_seq[i].bits,      exp_seq[i].bits);
            check({ph, "_seq_ovf"},  32'(obs_seq[i].ovf),  32'(exp_seq[i].ovf));
            check({ph, "_sos_det"},  32'(obs_seq[i].sos),  32'(exp_seq[i].sos));
            check({ph, "_led_pulse"},32'(obs_seq[i].led),  32'(exp_seq[i].led));
        end
        check({ph, "_held_len"},  32'(seq_len),  last_exp.len);
        check({ph, "_held_bits"}, 32'(seq_bits), last_exp.bits);
        check({ph, "_held_ovf"},  32'(seq_ovf),  32'(last_exp.ovf));
        check({ph, "_led_g"},     32'(led_g),    32'(exp_led));
        exp_sym.delete();
        exp_seq.delete();
        obs_sym.delete();
        obs_seq.delete();
    endtask

    task automatic check_reset_outputs(input string ph);
        check({ph, "_sym_valid"}, 32'(sym_valid), 32'd0);
        check({ph, "_sym_dash"},  32'(sym_dash),  32'd0);
        check({ph, "_seq_valid"}, 32'(seq_valid), 32'd0);
        check({ph, "_seq_len"},   32'(seq_len),   32'd0);
        check({ph, "_seq_bits"},  32'(seq_bits),  32'd0);
        check({ph, "_seq_ovf"},   32'(seq_ovf),   32'd0);
        check({ph, "_sos_det"},   32'(sos_det),   32'd0);
        check({ph, "_led_g"},     32'(led_g),     32'd1);
    endtask

    task automatic send_sos();
        for (int i = 0; i < 9; i++) begin
            send_mark((i >= 3 && i < 6) ? 150 : 50);
            if (i != 8) send_space(55);
        end
        flush();
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 10);

        // SOS
        send_sos();
        check("sos_bits_out", 32'(seq_bits), 32'h0038);
        check("sos_len_out",  32'(seq_len),  32'd9);
        check("sos_led_on",   32'(led_g),    32'd0);
        compare_all("sos");

        // Glitches: 3 cycles is absorbed by the filter, 8 passes but is noise
        drive(1'b0, 3);
        drive(1'b1, 50);
        send_mark(8);
        flush();
        compare_all("glitch");

        // Dot/dash threshold
        send_mark(99);
        send_space(55);
        send_mark(100);
        flush();
        check("thr_bits_out", 32'(seq_bits), 32'h0001);
        check("thr_len_out",  32'(seq_len),  32'd2);
        compare_all("thresh");

        // 17 dots overflow
        for (int i = 0; i < 17; i++) begin
            send_mark(50);
            if (i != 16) send_space(55);
        end
        flush();
        check("ovf_flag_out", 32'(seq_ovf), 32'd1);
        check("ovf_len_out",  32'(seq_len), 32'd16);
        compare_all("ovf");

        // Word-gap boundary
        send_mark(50);
        send_space(WG - 1);
        send_mark(50);
        flush();
        check("gap399_len", 32'(seq_len), 32'd2);
        compare_all("gap399");
        send_mark(50);
        send_space(WG);
        send_mark(50);
        flush();
        compare_all("gap400");

        // Reset in the middle of a sequence with the key held down
        send_sos();
        compare_all("sos2");
        send_mark(50);
        send_space(55);
        compare_all("pre_rst");
        drive(1'b0, 30);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 60);
        #1;
        check("rst_no_sym_early", obs_sym.size(), 0);
        check("rst_no_seq_early", obs_seq.size(), 0);
        model_mark(60, 0);
        last_space = 55;
        flush();
        compare_all("post_rst");

        // Randomised sequences
        for (int r = 0; r < 5; r++) begin
            int n_el;
            n_el = $urandom_range(1, 10);
            for (int e = 0; e < n_el; e++) begin
                int kind;
                int sel;
                kind = $urandom_range(0, 9);
                if (kind == 0)      send_mark($urandom_range(4, 8));
                else if (kind < 6)  send_mark($urandom_range(15, 85));
                else                send_mark($urandom_range(110, 250));
                if (e != n_el - 1) begin
                    sel = $urandom_range(0, 9);
                    if (sel == 0)      send_space(WG);
                    else if (sel == 1) send_space(WG + 1);
                    else if (sel == 2) send_space(WG - 1);
                    else               send_space($urandom_range(20, 200));
                end
            end
            flush();
            compare_all($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
